fifo_ctrl: RTL

Pointer and flag controller that turns the 16 x 8 inferred block RAM into a synchronous FIFO. It sits directly in front of the memory and drives its write port (`w_en`, `w_addr`, `w_data`) and read port (`r_en`, `r_addr`). Producers push bytes in, and consumers pop them out. The popped data emerges on the memory's registered `r_data`, qualified by this block's `rd_valid`.

---
 rtl/fifo_pkg.sv | 15 +
 rtl/wrap_ptr.sv | 34 +++
 rtl/fifo_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared constants for the FIFO controller slice: default memory geometry,
// the derived depth, and the index of each pointer in the pointer bank.
package fifo_pkg;

    localparam int FIFO_ADDR_WIDTH = 4;
    localparam int FIFO_DATA_WIDTH = 8;
    localparam int FIFO_DEPTH      = 1 << FIFO_ADDR_WIDTH;

    // Pointer bank layout: the controller keeps its two pointers side by side.
    localparam int PTR_WR   = 0;
    localparam int PTR_RD   = 1;
    localparam int NUM_PTRS = 2;

endpackage

// File: rtl/wrap_ptr.sv
// wrap_ptr
// WIDTH-bit wrapping pointer. The MSB acts as the wrap bit when the low
// WIDTH-1 bits address the memory, so it toggles every full lap.
// Ports:
//   clk    clock, state updates on rising edge
//   rst    asynchronous active-high reset, pointer -> 0
//   clear  synchronous flush, pointer -> 0 (beats inc)
//   inc    advance pointer by one
//   ptr    current pointer value
module wrap_ptr #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] ptr
);

    logic [WIDTH-1:0] ptr_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= '0;
        end else if (clear) begin
            ptr_reg <= '0;
        end else if (inc) begin
            ptr_reg <= ptr_reg + WIDTH'(1);
        end
    end

    assign ptr = ptr_reg;

endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl
// Pointer/flag controller that turns a simple dual-port RAM with registered
// read into a synchronous FIFO.
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   clear               synchronous flush (pointers, rd_valid, error flags)
//   push, push_data     enqueue request and its data
//   pop                 dequeue request
//   mem_w_en/addr/data  memory write port (combinational from push)
//   mem_r_en/addr       memory read port (combinational from pop)
//   rd_valid            memory r_data carries a popped word this cycle
//   full, empty, almost_full, count   status from registered pointers
//   overflow, underflow sticky error flags, cleared by rst or clear
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH  = FIFO_ADDR_WIDTH,
    parameter int DATA_WIDTH  = FIFO_DATA_WIDTH,
    parameter int AFULL_LEVEL = (FIFO_DEPTH * 3) / 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  mem_w_en,
    output logic [ADDR_WIDTH-1:0] mem_w_addr,
    output logic [DATA_WIDTH-1:0] mem_w_data,
    output logic                  mem_r_en,
    output logic [ADDR_WIDTH-1:0] mem_r_addr,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] AFULL_THRESH = (ADDR_WIDTH + 1)'(AFULL_LEVEL);

    logic [ADDR_WIDTH:0] ptr_q [NUM_PTRS];
    logic [NUM_PTRS-1:0] ptr_inc;
    logic [ADDR_WIDTH:0] wr_ptr;
    logic [ADDR_WIDTH:0] rd_ptr;

    logic push_ok;
    logic pop_ok;

    logic rd_valid_reg;
    logic overflow_reg;
    logic underflow_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PTRS; gi++) begin : g_ptr
            wrap_ptr #(
                .WIDTH (ADDR_WIDTH + 1)
            ) u_ptr (
                .clk   (clk),
                .rst   (rst),
                .clear (clear),
                .inc   (ptr_inc[gi]),
                .ptr   (ptr_q[gi])
            );
        end
    endgenerate

    assign wr_ptr = ptr_q[PTR_WR];
    assign rd_ptr = ptr_q[PTR_RD];

    // Status flags come straight from the registered pointers, so they lag
    // an accepted operation by one cycle.
    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                         (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
    assign count       = wr_ptr - rd_ptr;
    assign almost_full = (count >= AFULL_THRESH);

    // Acceptance looks only at the registered flags: no pass-through when
    // full and no fall-through when empty. A flush suppresses both ports so
    // the memory is not touched in a clear cycle.
    assign push_ok = push && !full && !clear;
    assign pop_ok  = pop && !empty && !clear;

    assign ptr_inc[PTR_WR] = push_ok;
    assign ptr_inc[PTR_RD] = pop_ok;

    // Memory port muxing; forced idle while reset is held.
    assign mem_w_en   = push_ok && !rst;
    assign mem_w_addr = wr_ptr[ADDR_WIDTH-1:0];
    assign mem_w_data = push_data;
    assign mem_r_en   = pop_ok && !rst;
    assign mem_r_addr = rd_ptr[ADDR_WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_reg  <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else if (clear) begin
            rd_valid_reg  <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            // Memory r_data registers on the same edge, so they line up.
            rd_valid_reg <= pop_ok;
            if (push && full) begin
                overflow_reg <= 1'b1;
            end
            if (pop && empty) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    assign rd_valid  = rd_valid_reg;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

endmodule
